// File: rtl/reg_file_demux.sv
// 32 x 32 MIPS register file: one-hot decoded write port, two registered operand
// read ports with optional write-first forwarding, and a combinational debug port.
module reg_file_demux #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [DEPTH-1:0] wr_onehot
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_dec;
    logic [WIDTH-1:0] w_rval0;
    logic [WIDTH-1:0] w_rval1;

    // Entry 0 is never enabled, so $zero can only ever hold its reset value.
    always_comb begin
        w_dec = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_dec[i] = we && (waddr == AW'(i));
        end
    end

    always_comb begin
        w_rval0 = r_mem[raddr0];
        if (raddr0 == '0) begin
            w_rval0 = '0;
        end else if ((BYPASS != 0) && we && (waddr == raddr0)) begin
            w_rval0 = wdata;
        end
    end

    always_comb begin
        w_rval1 = r_mem[raddr1];
        if (raddr1 == '0) begin
            w_rval1 = '0;
        end else if ((BYPASS != 0) && we && (waddr == raddr1)) begin
            w_rval1 = wdata;
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            rdata0    <= '0;
            rdata1    <= '0;
            wr_onehot <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_dec[i]) begin
                    r_mem[i] <= wdata;
                end
            end
            wr_onehot <= w_dec;
            if (re) begin
                rdata0 <= w_rval0;
                rdata1 <= w_rval1;
            end
        end
    end

endmodule

// File: doc/reg_file_demux.md
Name: reg_file_demux

Overview:
- 32 x 32-bit MIPS general-purpose register file. It is the write-side counterpart of the datapath operand selectors.
- Write side: a 5-bit address is decoded, one-hot, to a single register's write enable. Read side: two ports return registered operand data.
- Sits between the writeback stage (write port) and decode/execute (read ports). Register $zero is hardwired to 0.
- A third debug read port serves the testbench and monitors.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; the address width is log2(DEPTH) = 5.
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = reads return the pre-write value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- we  input  1  write enable from writeback.
- waddr  input  5  write register index.
- wdata  input  WIDTH  write data.
- re  input  1  read strobe for both operand ports; when 0, rdata0/rdata1 hold their values.
- raddr0  input  5  read index, port 0 (rs).
- raddr1  input  5  read index, port 1 (rt).
- rdata0  output  WIDTH  registered read data, port 0.
- rdata1  output  WIDTH  registered read data, port 1.
- dbg_addr  input  5  debug read index.
- dbg_data  output  WIDTH  combinational debug read of the array; no bypass applied.
- wr_onehot  output  DEPTH  registered copy of the decoded write enables from the last cycle; all 0 if no write occurred.

Behaviour:
- Reset:
  - rst_n = 0 sampled at a rising clk edge clears all 32 registers, rdata0, rdata1 and wr_onehot to 0.
  - Reset overrides we and re in the same cycle.
  - Reset mid-operation discards any write presented in that cycle.
- Write decode:
  - dec[i] = we & (waddr == i) for i = 1..31.
  - dec[0] is forced to 0, so writes to register 0 are silently dropped.
  - On a clock edge, reg[i] <= wdata where dec[i] = 1. At most one register is written per cycle.
  - wr_onehot <= dec on every edge.
- Read:
  - If re = 1 at an edge: rdata0 <= value(raddr0) and rdata1 <= value(raddr1). Latency is 1 cycle from address to data.
  - If re = 0: rdata0 and rdata1 hold.
  - value(a) = 0 when a == 0.
  - Otherwise, when BYPASS = 1 and we = 1 and waddr == a, value(a) = wdata (write-first).
  - Otherwise value(a) = reg[a], the pre-edge contents.
  - Both ports may address the same register, and both may match waddr. Each port resolves independently with the same rule.
- Debug port: dbg_data = (dbg_addr == 0) ? 0 : reg[dbg_addr], read combinationally from the array state.
- Boundaries:
  - A write to register 0 with re = 1 and raddr0 = 0 returns 0 regardless of BYPASS.
  - Back-to-back writes to the same index: the last write wins, and a read in the following cycle sees the latest value.
  - X on waddr while we = 0 must not corrupt any register.
- No stall/busy output. The block accepts one write and one read pair every cycle.
- All state updates occur on the rising edge only. There are no latches; combinational decode is complete for every waddr value.

Test Plan:
- Reset, then re = 1 with raddr0 = 5 and raddr1 = 31 → rdata0 = rdata1 = 0; wr_onehot = 0; dbg_data = 0 for every address.
- Write 0xDEADBEEF to register 7, next cycle read raddr0 = 7 → rdata0 = 0xDEADBEEF one cycle after the read; wr_onehot = 0x00000080 after the write edge.
- BYPASS = 1: in one cycle we = 1, waddr = 3, wdata = 0x12345678, re = 1, raddr0 = raddr1 = 3 → both rdata = 0x12345678 next cycle. Repeat with BYPASS = 0, where register 3 previously held 0x1 → both rdata = 0x1; dbg_data at address 3 then reads 0x12345678.
- Write 0xFFFFFFFF to register 0 → dbg_data(0) = 0; a read of raddr0 = 0 returns 0; wr_onehot = 0.
- Fill registers 1..31 with their own index; assert rst_n = 0 for one edge while we = 1, waddr = 9, wdata = 0xAAAA → all registers read 0 afterwards, register 9 included.
- re = 0 for three cycles while registers change → rdata0 and rdata1 hold their prior values; re = 1 → they update to the current contents.
